pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Duty-cycle sequencer for the `pwm` block. It owns the `duty` input of one `pwm` instance and ramps it from its current value to a commanded target in fixed steps, one step every `rate` PWM periods, so LED brightness or motor drive fades smoothly instead of jumping. It sits between user/control logic (buttons, UART command decoder) and `pwm`, and runs on the board's 100 MHz `clk`.

## Interface
- `SIZE`, 8: duty width; must equal the `pwm` instance's size parameter.
- `PERIOD`, 255: clock cycles per PWM period; must equal the `pwm` instance's period parameter (≥2).
- `STEP`, 16: duty change per update (1..2^SIZE-1).

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle command strobe; latches `target` and `rate`.
- `abort` in 1: stop ramp, freeze duty.
- `target` in SIZE: final duty value.
- `rate` in 8: PWM periods per step; 0 treated as 1.
- `breathe` in 1: continuous fade mode (only with `FADE_BREATHE_EN`).
- `duty` out SIZE: registered; connects to `pwm.duty`.
- `busy` out 1: ramp in progress.
- `done` out 1: one-cycle pulse, target reached.

## Operation
- Reset values: `duty`=0, `busy`=0, `done`=0, state IDLE, all counters 0, latched target/rate 0.
- Period counter `pcnt`: free-running 0..PERIOD-1, wraps; `tick` = (`pcnt`==PERIOD-1). Runs in every state; it is never cleared except by reset.
- Rate counter `rcnt`: advances on `tick` only while ramping; when `rcnt`==max(rate_q,1)-1 on a tick, a step is applied and `rcnt` clears.
- States: IDLE, UP, DOWN.
  - IDLE + `start`: latch `target_q`, `rate_q`, clear `rcnt`. If `target`>`duty` → UP; `target`<`duty` → DOWN; equal → stay IDLE and pulse `done`.
  - UP step: `duty` += STEP, clamped to `target_q`. DOWN step: `duty` -= STEP, clamped to `target_q`. No wrap or underflow ever occurs.
  - When the step lands on `target_q`: → IDLE, `busy`→0 and `done`→1 on the same edge.
  - UP/DOWN + `start` (retarget): relatch target/rate, clear `rcnt`, and re-evaluate direction against the current `duty`. If the new target equals `duty`, → IDLE with `done`.
  - Any state + `abort`: → IDLE. `duty` holds its value, `rcnt` clears, no `done`.
- Priority: `rst` > `abort` > `start` > step.
- `busy` = (state != IDLE), registered.

## Timing
- `start` is sampled on edge N. State, `busy`, and latched values update at N; `busy` is visible from cycle N+1.
- First step occurs on the rate_q-th `tick` after the start edge. A tick on the start edge itself does not count.
- `duty` changes only on `tick` edges, so `pwm` sees at most one change per PWM period, aligned to the controller's period wrap.
- `done` is high for exactly one cycle. If `start` arrives while `done` is high, the new command is accepted normally.
- Ramp length = ceil(|target-duty|/STEP) steps × max(rate,1) × PERIOD cycles, ± one period for start alignment.
- An asynchronous `rst` mid-ramp forces `duty`=0 immediately. This is a glitch on `pwm.duty`, which is acceptable.

## Configuration
- `FADE_BREATHE_EN` defined: the `breathe` port exists. If `breathe`=1 at `start`, reaching `target_q` reverses the direction toward 0, and reaching 0 reverses toward `target_q`, indefinitely. `done` never pulses in this mode and `busy` stays 1 until `abort`. Target 0 in breathe mode behaves as single-shot.
- `FADE_BREATHE_EN` not defined: the `breathe` port and reversal logic are absent. All ramps are single-shot.

## Test plan
- Reset mid-ramp: `rst` pulse during an UP ramp → `duty`=0, `busy`=0, `done`=0 asynchronously; `pcnt` restarts at 0.
- Up ramp (SIZE=8, PERIOD=255, STEP=16): from `duty`=0, `start` with target=128, rate=1 → `duty` steps 16,32,…,128 on 8 consecutive ticks 255 cycles apart; `done` pulses once on the 128 edge; `busy` falls on the same edge.
- Clamp and down ramp: from `duty`=128, target=100, rate=2 → `duty` 112 then 100, two ticks apart each; never below 100.
- Equal target and zero rate: `start` with target=`duty` → `done` next cycle, `busy` stays 0. Separately, rate=0 behaves identically to rate=1.
- Retarget and abort: during ramp 0→192, `start` target=32 when `duty`=64 → direction flips to DOWN and ends at 32 with `done`. Then `abort` during a new ramp at `duty`=80 → `duty` holds 80, no `done`. `abort`+`start` in the same cycle → abort wins.
- `FADE_BREATHE_EN`: `breathe`=1, target=64, STEP=32 → `duty` 32,64,32,0,32,64… with `busy` held high and no `done`; `abort` freezes the current value.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for one pwm instance: ramps duty toward a target by STEP every rate PWM periods.
// Optional continuous breathing between target and 0 is compiled in with FADE_BREATHE_EN.
module pwm_fade_ctrl #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned PERIOD = 255,
  parameter int unsigned STEP   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [SIZE-1:0] target,
  input  logic [7:0]      rate,
`ifdef FADE_BREATHE_EN
  input  logic            breathe,
`endif
  output logic [SIZE-1:0] duty,
  output logic            busy,
  output logic            done
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]   PCNT_MAX = PW'(PERIOD - 1);
  localparam logic [SIZE-1:0] STEP_V   = SIZE'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [7:0]      rcnt, rcnt_nxt;
  logic [7:0]      rate_q, rate_nxt;
  logic [7:0]      rate_last;
  logic [SIZE-1:0] target_q, target_nxt;
  logic [SIZE-1:0] goal;
  logic [SIZE-1:0] up_val, dn_val, step_val;
  logic [SIZE-1:0] duty_nxt;
  logic            busy_nxt, done_nxt;
`ifdef FADE_BREATHE_EN
  logic [SIZE-1:0] goal_q, goal_nxt;
  logic            breathe_q, breathe_nxt;
  assign goal = goal_q;
`else
  assign goal = target_q;
`endif

  // Free-running period counter, aligned with the pwm instance's period wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == PCNT_MAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick      = (pcnt == PCNT_MAX);
  assign rate_last = (rate_q == 8'd0) ? 8'd0 : rate_q - 8'd1;

  // Candidate step values; the clamp keeps duty from passing the goal in either direction.
  assign up_val   = ((goal - duty) <= STEP_V) ? goal : duty + STEP_V;
  assign dn_val   = ((duty - goal) <= STEP_V) ? goal : duty - STEP_V;
  assign step_val = (state == UP) ? up_val : dn_val;

  // State and registered-output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rcnt     <= '0;
      rate_q   <= '0;
      target_q <= '0;
`ifdef FADE_BREATHE_EN
      goal_q    <= '0;
      breathe_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rcnt     <= rcnt_nxt;
      rate_q   <= rate_nxt;
      target_q <= target_nxt;
`ifdef FADE_BREATHE_EN
      goal_q    <= goal_nxt;
      breathe_q <= breathe_nxt;
`endif
    end
  end

  // Next-state: abort beats start, start beats a pending step.
  always_comb begin
    state_nxt  = state;
    duty_nxt   = duty;
    rcnt_nxt   = rcnt;
    rate_nxt   = rate_q;
    target_nxt = target_q;
    done_nxt   = 1'b0;
`ifdef FADE_BREATHE_EN
    goal_nxt    = goal_q;
    breathe_nxt = breathe_q;
`endif
    if (abort) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else if (start) begin
      target_nxt = target;
      rate_nxt   = rate;
      rcnt_nxt   = '0;
`ifdef FADE_BREATHE_EN
      goal_nxt    = target;
      breathe_nxt = breathe;
`endif
      if (target > duty) begin
        state_nxt = UP;
      end else if (target < duty) begin
        state_nxt = DOWN;
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end else if (state != IDLE && tick) begin
      if (rcnt == rate_last) begin
        rcnt_nxt = '0;
        duty_nxt = step_val;
        if (step_val == goal) begin
`ifdef FADE_BREATHE_EN
          if (breathe_q && target_q != '0) begin
            // Bounce between target_q and 0 forever.
            goal_nxt  = (goal_q == target_q) ? '0 : target_q;
            state_nxt = (goal_nxt > step_val) ? UP : DOWN;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end
      end else begin
        rcnt_nxt = rcnt + 8'd1;
      end
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: predicted duty steps and done pulses (value and cycle) are queued
// at each start and consumed by a negedge monitor.
module tb_pwm_fade_ctrl;
  localparam int SIZE   = 8;
  localparam int PERIOD = 255;
  localparam int STEP   = 16;

  typedef struct {
    int duty;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] rate = 8'd0;
`ifdef FADE_BREATHE_EN
  logic       breathe = 1'b0;
`endif
  logic [7:0] duty;
  logic       busy;
  logic       done;

  exp_t sq[$];
  int   dq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_pcnt = 0;
  int   m_cur = 0;
  logic [7:0] prev = 8'd0;
  exp_t me;
  int   mdc;

  pwm_fade_ctrl #(.SIZE(SIZE), .PERIOD(PERIOD), .STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .target(target),
    .rate(rate),
`ifdef FADE_BREATHE_EN
    .breathe(breathe),
`endif
    .duty(duty),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) m_pcnt <= 0;
    else m_pcnt <= (m_pcnt == PERIOD - 1) ? 0 : m_pcnt + 1;
  end

  // Monitor: every duty change and every done cycle must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      prev = duty;
    end else begin
      if (duty !== prev) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL duty_change: unexpected duty=%0d at cycle %0d", duty, cyc);
        end else begin
          me = sq.pop_front();
          m_cur = me.duty;
          if (duty !== 8'(me.duty) || cyc != me.cyc) begin
            bad++;
            $display("FAIL duty_step: got %0d at cycle %0d, want %0d at cycle %0d", duty, cyc, me.duty, me.cyc);
          end
        end
        prev = duty;
      end
      if (done === 1'b1) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_pulse: unexpected done at cycle %0d", cyc);
        end else begin
          mdc = dq.pop_front();
          if (cyc != mdc) begin
            bad++;
            $display("FAIL done_time: got cycle %0d, want cycle %0d", cyc, mdc);
          end
        end
      end
    end
  end

  task automatic do_start(input int tgt, input int rt, input bit brth, input int nb);
    int p, d, r, t, cur, goal, n;
    bit exp_b;
    exp_t e;
    @(negedge clk);
    #1;
    start = 1'b1;
    target = 8'(tgt);
    rate = 8'(rt);
`ifdef FADE_BREATHE_EN
    breathe = brth;
`endif
    sq.delete();
    dq.delete();
    p = m_pcnt;
    d = (p == PERIOD - 1) ? PERIOD : (PERIOD - 1 - p);
    r = (rt == 0) ? 1 : rt;
    t = cyc + 1 + d + (r - 1) * PERIOD;
    cur = m_cur;
    goal = tgt;
    exp_b = (cur != tgt);
    n = 0;
    if (cur == tgt) begin
      dq.push_back(cyc + 1);
    end else begin
      while (1) begin
        if (goal > cur) cur = (goal - cur <= STEP) ? goal : cur + STEP;
        else cur = (cur - goal <= STEP) ? goal : cur - STEP;
        e.duty = cur;
        e.cyc = t + n * r * PERIOD;
        sq.push_back(e);
        n++;
        if (cur == goal) begin
          if (brth && tgt != 0) goal = (goal == tgt) ? 0 : tgt;
          else begin
            dq.push_back(t + (n - 1) * r * PERIOD);
            break;
          end
        end
        if (brth && n >= nb) break;
      end
    end
    @(negedge clk);
    #1;
    start = 1'b0;
`ifdef FADE_BREATHE_EN
    breathe = 1'b0;
`endif
    total++;
    if (busy !== exp_b) begin
      bad++;
      $display("FAIL start_busy: busy=%0b want %0b (target %0d)", busy, exp_b, tgt);
    end
  endtask

  task automatic wait_drain(input string name, input int budget, input bit exp_busy);
    int k;
    k = 0;
    while ((sq.size() != 0 || dq.size() != 0) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (sq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d steps and %0d dones still pending, want 0", name, sq.size(), dq.size());
    end
    @(negedge clk);
    #1;
    total++;
    if (busy !== exp_busy || done !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: busy=%0b done=%0b, want busy=%0b done=0", name, busy, done, exp_busy);
    end
  endtask

  task automatic wait_duty(input string name, input int val, input int budget);
    int k;
    k = 0;
    while (duty !== 8'(val) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    total++;
    if (duty !== 8'(val)) begin
      bad++;
      $display("FAIL %s_wait: duty=%0d, want %0d", name, duty, val);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: duty=%0d busy=%0b done=%0b, want 0 0 0", duty, busy, done);
    end
    rst = 1'b0;
    m_cur = 0;
  endtask

  task automatic test_up_ramp;
    do_start(128, 1, 1'b0, 0);
    wait_drain("up_ramp", 9 * PERIOD + 50, 1'b0);
  endtask

  task automatic test_down_clamp;
    do_start(100, 2, 1'b0, 0);
    wait_drain("down_clamp", 3 * 2 * PERIOD + 50, 1'b0);
  endtask

  task automatic test_equal_rate0;
    do_start(100, 5, 1'b0, 0);
    wait_drain("equal_target", 5, 1'b0);
    do_start(132, 0, 1'b0, 0);
    wait_drain("rate_zero", 3 * PERIOD + 50, 1'b0);
  endtask

  task automatic test_retarget_abort;
    do_start(0, 1, 1'b0, 0);
    wait_drain("down_to_zero", 10 * PERIOD + 50, 1'b0);
    do_start(192, 1, 1'b0, 0);
    wait_duty("retarget", 64, 5 * PERIOD + 50);
    do_start(32, 1, 1'b0, 0);
    wait_drain("retarget", 3 * PERIOD + 50, 1'b0);
    do_start(160, 1, 1'b0, 0);
    wait_duty("abort", 80, 4 * PERIOD + 50);
    @(negedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    sq.delete();
    dq.delete();
    repeat (2 * PERIOD + 20) @(negedge clk);
    #1;
    total++;
    if (duty !== 8'd80 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: duty=%0d busy=%0b, want 80 0", duty, busy);
    end
    abort = 1'b1;
    start = 1'b1;
    target = 8'd200;
    rate = 8'd1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_busy: busy=%0b, want 0", busy);
    end
    repeat (2 * PERIOD + 20) @(negedge clk);
    #1;
    total++;
    if (duty !== 8'd80 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_hold: duty=%0d busy=%0b, want 80 0", duty, busy);
    end
  endtask

  task automatic test_reset_mid_ramp;
    do_start(128, 1, 1'b0, 0);
    wait_duty("reset_mid", 112, 3 * PERIOD + 50);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async: duty=%0d busy=%0b done=%0b, want 0 0 0", duty, busy, done);
    end
    sq.delete();
    dq.delete();
    m_cur = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    do_start(32, 1, 1'b0, 0);
    wait_drain("after_reset", 3 * PERIOD + 50, 1'b0);
  endtask

`ifdef FADE_BREATHE_EN
  task automatic test_breathe;
    do_start(64, 1, 1'b1, 12);
    wait_drain("breathe", 13 * PERIOD + 50, 1'b1);
    @(negedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    sq.delete();
    dq.delete();
    repeat (2 * PERIOD + 20) @(negedge clk);
    #1;
    total++;
    if (duty !== 8'd32 || busy !== 1'b0) begin
      bad++;
      $display("FAIL breathe_abort: duty=%0d busy=%0b, want 32 0", duty, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_ramp();
    test_down_clamp();
    test_equal_rate0();
    test_retarget_abort();
    test_reset_mid_ramp();
`ifdef FADE_BREATHE_EN
    test_breathe();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
